io_port_unit: RTL and testbench

Buffered I/O port for the multicycle CPU. It sits downstream of the control unit and register file. It captures register data on `out` instructions into an output FIFO that drains to an external device. It also buffers words from an external source into an input FIFO, whose head feeds the `MemtoReg = 2'b10` write-back path on `in` instructions. The control unit never stalls, so overrun and underrun are absorbed here and reported through sticky flags.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/io_fifo.sv | 56 +++++
 rtl/io_port_unit.sv | 70 +++++++
 tb/tb_io_port_unit.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: word width, write-back select encoding and I/O opcode decode.
package cpu_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {
    MTR_MEM = 2'd0,
    MTR_ALU = 2'd1,
    MTR_IO  = 2'd2
  } memtoReg_t;

  localparam logic [3:0] OP_IO   = 4'b1100;
  localparam logic [3:0] FUNK_IN = 4'd1;

  // InRead as the CPU top derives it from the write-back controls.
  function automatic logic isInRead(input logic regWrite, input logic [1:0] memtoReg);
    return regWrite && (memtoReg == MTR_IO);
  endfunction

  // Any funk other than FUNK_IN under OP_IO is an `out`.
  function automatic logic isIoIn(input logic [3:0] opcode, input logic [3:0] funk);
    return (opcode == OP_IO) && (funk == FUNK_IN);
  endfunction

endpackage

// File: rtl/io_fifo.sv
// First-word-fall-through circular FIFO; refuses push when full and pop when empty.
module io_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [CW-1:0]    count;
  logic             doPush;
  logic             doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign doPush = push & ~full;
  assign doPop  = pop & ~empty;
  assign rdata  = mem[rdPtr];

  // Pointers are exactly log2(DEPTH) wide, so increments wrap modulo DEPTH.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wdata;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_port_unit.sv
// Buffered CPU I/O port: output FIFO toward an external sink, input FIFO feeding write-back.
module io_port_unit
  import cpu_pkg::*;
#(
  parameter int WIDTH     = WORD_W,
  parameter int OUT_DEPTH = 4,
  parameter int IN_DEPTH  = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             OutputWrite,
  input  logic [WIDTH-1:0] OutData,
  input  logic             InRead,
  output logic [WIDTH-1:0] InData,
  output logic [WIDTH-1:0] ext_out_data,
  output logic             ext_out_valid,
  input  logic             ext_out_ready,
  input  logic [WIDTH-1:0] ext_in_data,
  input  logic             ext_in_valid,
  output logic             ext_in_ready,
  output logic             OutFull,
  output logic             InEmpty,
  output logic             Overflow,
  output logic             Underflow,
  input  logic             ClearErr
);

  logic             outEmpty;
  logic             inFull;
  logic [WIDTH-1:0] inHead;

  io_fifo #(.WIDTH(WIDTH), .DEPTH(OUT_DEPTH)) outFifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (OutputWrite),
    .pop   (ext_out_ready),
    .wdata (OutData),
    .rdata (ext_out_data),
    .full  (OutFull),
    .empty (outEmpty)
  );

  io_fifo #(.WIDTH(WIDTH), .DEPTH(IN_DEPTH)) inFifo (
    .CLK   (CLK),
    .Reset (Reset),
    .push  (ext_in_valid),
    .pop   (InRead),
    .wdata (ext_in_data),
    .rdata (inHead),
    .full  (inFull),
    .empty (InEmpty)
  );

  assign ext_out_valid = ~outEmpty;
  assign ext_in_ready  = ~inFull;
  // Stale words stay in storage after a pop, so an empty FIFO must read as zero.
  assign InData        = InEmpty ? '0 : inHead;

  // A set condition in the same cycle as ClearErr keeps the flag high.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      Overflow  <= (Overflow & ~ClearErr) | (OutputWrite & OutFull);
      Underflow <= (Underflow & ~ClearErr) | (InRead & InEmpty);
    end
  end

endmodule

// File: tb/tb_io_port_unit.sv
// Directed self-checking bench for io_port_unit.
module tb_io_port_unit;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        OutputWrite;
  logic [15:0] OutData;
  logic        InRead;
  logic [15:0] InData;
  logic [15:0] ext_out_data;
  logic        ext_out_valid;
  logic        ext_out_ready;
  logic [15:0] ext_in_data;
  logic        ext_in_valid;
  logic        ext_in_ready;
  logic        OutFull;
  logic        InEmpty;
  logic        Overflow;
  logic        Underflow;
  logic        ClearErr;

  int passCount = 0;
  int totalCount = 0;

  io_port_unit #(.WIDTH(16), .OUT_DEPTH(4), .IN_DEPTH(4)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .OutputWrite   (OutputWrite),
    .OutData       (OutData),
    .InRead        (InRead),
    .InData        (InData),
    .ext_out_data  (ext_out_data),
    .ext_out_valid (ext_out_valid),
    .ext_out_ready (ext_out_ready),
    .ext_in_data   (ext_in_data),
    .ext_in_valid  (ext_in_valid),
    .ext_in_ready  (ext_in_ready),
    .OutFull       (OutFull),
    .InEmpty       (InEmpty),
    .Overflow      (Overflow),
    .Underflow     (Underflow),
    .ClearErr      (ClearErr)
  );

  always #5 CLK = ~CLK;

  // Inputs change and outputs are sampled at the falling edge.
  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idleInputs();
    OutputWrite   = 1'b0;
    OutData       = '0;
    InRead        = 1'b0;
    ext_out_ready = 1'b0;
    ext_in_data   = '0;
    ext_in_valid  = 1'b0;
    ClearErr      = 1'b0;
  endtask

  task automatic test_reset();
    idleInputs();
    Reset = 1'b1;
    #1;
    totalCount++; if (InData !== 16'h0000) $display("FAIL reset_indata got %h want 0000", InData); else passCount++;
    totalCount++; if (ext_out_data !== 16'h0000) $display("FAIL reset_outdata got %h want 0000", ext_out_data); else passCount++;
    totalCount++; if (ext_out_valid !== 1'b0) $display("FAIL reset_outvalid got %b want 0", ext_out_valid); else passCount++;
    totalCount++; if (ext_in_ready !== 1'b1) $display("FAIL reset_inready got %b want 1", ext_in_ready); else passCount++;
    totalCount++; if (OutFull !== 1'b0) $display("FAIL reset_outfull got %b want 0", OutFull); else passCount++;
    totalCount++; if (InEmpty !== 1'b1) $display("FAIL reset_inempty got %b want 1", InEmpty); else passCount++;
    totalCount++; if ({Overflow, Underflow} !== 2'b00) $display("FAIL reset_flags got %b want 00", {Overflow, Underflow}); else passCount++;
    @(negedge CLK);
    Reset = 1'b0;
    step();
    step();
    totalCount++; if (ext_out_valid !== 1'b0 || InEmpty !== 1'b1 || InData !== 16'h0000)
      $display("FAIL idle_state got valid=%b empty=%b indata=%h want 0 1 0000", ext_out_valid, InEmpty, InData);
    else passCount++;
  endtask

  task automatic test_out_single();
    OutputWrite = 1'b1; OutData = 16'hA5A5;
    step();
    OutputWrite = 1'b0; OutData = 16'h0000;
    totalCount++; if (ext_out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", ext_out_valid); else passCount++;
    totalCount++; if (ext_out_data !== 16'hA5A5) $display("FAIL single_data got %h want a5a5", ext_out_data); else passCount++;
    step();
    totalCount++; if (ext_out_valid !== 1'b1) $display("FAIL single_hold got %b want 1", ext_out_valid); else passCount++;
    ext_out_ready = 1'b1;
    step();
    ext_out_ready = 1'b0;
    totalCount++; if (ext_out_valid !== 1'b0) $display("FAIL single_drop got %b want 0", ext_out_valid); else passCount++;
  endtask

  task automatic test_out_overflow();
    for (int i = 1; i <= 4; i++) begin
      OutputWrite = 1'b1; OutData = 16'(i);
      step();
    end
    OutputWrite = 1'b0;
    totalCount++; if (OutFull !== 1'b1) $display("FAIL fill_full got %b want 1", OutFull); else passCount++;
    totalCount++; if (Overflow !== 1'b0) $display("FAIL fill_no_ovf got %b want 0", Overflow); else passCount++;
    OutputWrite = 1'b1; OutData = 16'd5;
    step();
    OutputWrite = 1'b0;
    totalCount++; if (Overflow !== 1'b1) $display("FAIL ovf_set got %b want 1", Overflow); else passCount++;
    totalCount++; if (ext_out_data !== 16'd1) $display("FAIL ovf_head got %h want 0001", ext_out_data); else passCount++;
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    totalCount++; if (Overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", Overflow); else passCount++;
    // Full with a same-cycle pop: the write is still dropped.
    OutputWrite = 1'b1; OutData = 16'd6; ext_out_ready = 1'b1;
    step();
    OutputWrite = 1'b0;
    totalCount++; if (Overflow !== 1'b1) $display("FAIL ovf_with_pop got %b want 1", Overflow); else passCount++;
    totalCount++; if (OutFull !== 1'b0) $display("FAIL ovf_pop_full got %b want 0", OutFull); else passCount++;
    for (int i = 2; i <= 4; i++) begin
      totalCount++; if (ext_out_valid !== 1'b1 || ext_out_data !== 16'(i))
        $display("FAIL drain_%0d got valid=%b data=%h want 1 %h", i, ext_out_valid, ext_out_data, 16'(i));
      else passCount++;
      step();
    end
    ext_out_ready = 1'b0;
    totalCount++; if (ext_out_valid !== 1'b0) $display("FAIL drain_empty got %b want 0", ext_out_valid); else passCount++;
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    words[0] = 16'h0007; words[1] = 16'h0008; words[2] = 16'h0009;
    ext_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      OutputWrite = 1'b1; OutData = words[i];
      step();
      totalCount++; if (ext_out_valid !== 1'b1 || ext_out_data !== words[i])
        $display("FAIL b2b_%0d got valid=%b data=%h want 1 %h", i, ext_out_valid, ext_out_data, words[i]);
      else passCount++;
    end
    OutputWrite = 1'b0;
    step();
    ext_out_ready = 1'b0;
    totalCount++; if (ext_out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", ext_out_valid); else passCount++;
  endtask

  task automatic test_in_path();
    ext_in_valid = 1'b1; ext_in_data = 16'h0011;
    #1;
    totalCount++; if (InData !== 16'h0000) $display("FAIL in_pre_push got %h want 0000", InData); else passCount++;
    step();
    ext_in_data = 16'h0022;
    step();
    ext_in_valid = 1'b0; ext_in_data = 16'h0000;
    totalCount++; if (InEmpty !== 1'b0 || InData !== 16'h0011)
      $display("FAIL in_first got empty=%b data=%h want 0 0011", InEmpty, InData);
    else passCount++;
    InRead = 1'b1;
    step();
    InRead = 1'b0;
    totalCount++; if (InData !== 16'h0022) $display("FAIL in_second got %h want 0022", InData); else passCount++;
    InRead = 1'b1;
    step();
    InRead = 1'b0;
    totalCount++; if (InData !== 16'h0000 || InEmpty !== 1'b1)
      $display("FAIL in_drained got data=%h empty=%b want 0000 1", InData, InEmpty);
    else passCount++;
    totalCount++; if (Underflow !== 1'b0) $display("FAIL in_no_udf got %b want 0", Underflow); else passCount++;
    InRead = 1'b1;
    step();
    InRead = 1'b0;
    totalCount++; if (Underflow !== 1'b1 || InData !== 16'h0000)
      $display("FAIL in_underflow got udf=%b data=%h want 1 0000", Underflow, InData);
    else passCount++;
    ClearErr = 1'b1;
    step();
    ClearErr = 1'b0;
    totalCount++; if (Underflow !== 1'b0) $display("FAIL udf_clear got %b want 0", Underflow); else passCount++;
  endtask

  task automatic test_in_full_simul();
    logic [15:0] exp [4];
    for (int i = 1; i <= 4; i++) begin
      ext_in_valid = 1'b1; ext_in_data = 16'(i * 16);
      step();
      totalCount++; if (ext_in_ready !== (i < 4))
        $display("FAIL fill_ready_%0d got %b want %b", i, ext_in_ready, (i < 4));
      else passCount++;
    end
    totalCount++; if (InData !== 16'h0010) $display("FAIL full_head got %h want 0010", InData); else passCount++;
    ext_in_data = 16'h0050; InRead = 1'b1;
    step();
    InRead = 1'b0;
    totalCount++; if (ext_in_ready !== 1'b1 || InData !== 16'h0020)
      $display("FAIL full_pop got ready=%b data=%h want 1 0020", ext_in_ready, InData);
    else passCount++;
    step();
    ext_in_valid = 1'b0; ext_in_data = 16'h0000;
    totalCount++; if (ext_in_ready !== 1'b0) $display("FAIL refill_ready got %b want 0", ext_in_ready); else passCount++;
    exp[0] = 16'h0020; exp[1] = 16'h0030; exp[2] = 16'h0040; exp[3] = 16'h0050;
    for (int i = 0; i < 4; i++) begin
      totalCount++; if (InData !== exp[i]) $display("FAIL full_drain_%0d got %h want %h", i, InData, exp[i]); else passCount++;
      InRead = 1'b1;
      step();
      InRead = 1'b0;
    end
    totalCount++; if (InEmpty !== 1'b1 || Underflow !== 1'b0)
      $display("FAIL full_drain_end got empty=%b udf=%b want 1 0", InEmpty, Underflow);
    else passCount++;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) begin
      OutputWrite = 1'b1; OutData = 16'(16'h0100 + i);
      ext_in_valid = 1'b1; ext_in_data = 16'(16'h0200 + i);
      step();
    end
    OutputWrite = 1'b0; ext_in_valid = 1'b0;
    totalCount++; if (ext_out_valid !== 1'b1 || InData !== 16'h0200)
      $display("FAIL burst_loaded got valid=%b indata=%h want 1 0200", ext_out_valid, InData);
    else passCount++;
    Reset = 1'b1;
    #1;
    totalCount++; if (ext_out_valid !== 1'b0 || InEmpty !== 1'b1 || ext_in_ready !== 1'b1)
      $display("FAIL mid_reset got valid=%b empty=%b ready=%b want 0 1 1", ext_out_valid, InEmpty, ext_in_ready);
    else passCount++;
    totalCount++; if (InData !== 16'h0000 || ext_out_data !== 16'h0000)
      $display("FAIL mid_reset_data got in=%h out=%h want 0000 0000", InData, ext_out_data);
    else passCount++;
    @(negedge CLK);
    Reset = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      OutputWrite = 1'b1; OutData = 16'(i);
      step();
    end
    totalCount++; if (Overflow !== 1'b1) $display("FAIL pre_clear_ovf got %b want 1", Overflow); else passCount++;
    ClearErr = 1'b1;
    step();
    OutputWrite = 1'b0;
    totalCount++; if (Overflow !== 1'b1) $display("FAIL clear_vs_set got %b want 1", Overflow); else passCount++;
    step();
    ClearErr = 1'b0;
    totalCount++; if (Overflow !== 1'b0) $display("FAIL clear_alone got %b want 0", Overflow); else passCount++;
  endtask

  initial begin
    test_reset();
    test_out_single();
    test_out_overflow();
    test_back_to_back();
    test_in_path();
    test_in_full_simul();
    test_reset_mid();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
